// File: rtl/hash_mem_pkg.sv
// Shared definitions for the hash engine memory responder.
//   state_e        run sequencer states
//   WORD_W         RAM / engine data width
//   START_TIMEOUT  cycles to wait for the engine to drop done after a start
package hash_mem_pkg;

  localparam int WORD_W        = 32;
  localparam int START_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    COMPLETE  = 3'd4
  } state_e;

endpackage

// File: rtl/hash_mem_ram.sv
// DEPTH x WORD_W synchronous RAM, one write port and two registered read
// ports (a: engine side, b: host side).
//   clk, reset        clock, synchronous active-high reset (read regs only)
//   we/waddr/wdata    single write port, already arbitrated by the caller
//   a_addr/a_rdata    read port a, 1-cycle latency
//   b_addr/b_rdata    read port b, 1-cycle latency
// Both read ports are write-first: a read of the address being written in
// the same cycle returns the new data.
module hash_mem_ram
  import hash_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IW-1:0]     a_addr,
  output logic [WORD_W-1:0] a_rdata,
  input  logic [IW-1:0]     b_addr,
  output logic [WORD_W-1:0] b_rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] a_q, b_q;

  // Storage is never reset so preloaded data survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= (we && waddr == a_addr) ? wdata : mem_q[a_addr];
      b_q <= (we && waddr == b_addr) ? wdata : mem_q[b_addr];
    end
  end

  assign a_rdata = a_q;
  assign b_rdata = b_q;

endmodule

// File: rtl/hash_mem_responder.sv
// Memory-side responder for a hash engine: word-addressed RAM shared between
// a host port (preload / readback) and the engine port, plus a sequencer for
// one engine run (go -> start pulse -> wait for done -> irq).
//   clk, reset                    clock, synchronous active-high reset
//   mem_clk                       engine memory clock (must equal clk; unused)
//   mem_we/addr/write_data/read_data  engine memory port, 1-cycle read
//   host_req/we/addr/wdata        host access request
//   host_gnt                      host request accepted this cycle
//   host_rvalid/host_rdata        host read return, 1 cycle after grant
//   go                            request one engine run
//   hash_start                    one-cycle start pulse to the engine
//   hash_done                     engine done level
//   irq                           one-cycle pulse when a run completes
//   wr_count                      in-range engine writes this run (saturating)
//   err_oor                       sticky out-of-range access flag
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int                DEPTH    = 1024,
  parameter int                AW       = 16,
  parameter logic [WORD_W-1:0] OOR_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic              mem_we,
  input  logic [AW-1:0]     mem_addr,
  input  logic [WORD_W-1:0] mem_write_data,
  output logic [WORD_W-1:0] mem_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [WORD_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [WORD_W-1:0] host_rdata,
  input  logic              go,
  output logic              hash_start,
  input  logic              hash_done,
  output logic              irq,
  output logic [7:0]        wr_count,
  output logic              err_oor
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(START_TIMEOUT);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              done_q;
  logic              irq_q;
  logic              run_end;
  logic              host_rvalid_q;
  logic              eng_oor_q, host_oor_q;
  logic [7:0]        wr_count_q;
  logic              err_oor_q;

  logic              eng_own, host_open, launch;
  logic              eng_in, host_in;
  logic              eng_wr_ok, host_wr_ok, oor_evt;
  logic              ram_we;
  logic [IW-1:0]     ram_waddr;
  logic [WORD_W-1:0] ram_wdata, ram_a_rdata, ram_b_rdata;

  // mem_clk is the same net as clk by contract; kept only for port compatibility.
  logic unused_mem_clk;
  assign unused_mem_clk = mem_clk;

  assign eng_own   = (state_q == WAIT_BUSY) || (state_q == RUN);
  assign host_open = (state_q == IDLE) || (state_q == COMPLETE);
  assign host_gnt  = host_req & host_open;
  assign launch    = go & host_open;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  assign eng_in  = {1'b0, mem_addr}  < DEPTH_L;
  assign host_in = {1'b0, host_addr} < DEPTH_L;

  assign eng_wr_ok  = eng_own & mem_we & eng_in;
  assign host_wr_ok = host_gnt & host_we & host_in;
  // Engine accesses only count as accesses while it owns the RAM.
  assign oor_evt    = (eng_own & ~eng_in) | (host_gnt & ~host_in);

  // Ownership mux: the engine owns the write port for the whole run.
  assign ram_we    = eng_own ? eng_wr_ok : host_wr_ok;
  assign ram_waddr = eng_own ? mem_addr[IW-1:0] : host_addr[IW-1:0];
  assign ram_wdata = eng_own ? mem_write_data : host_wdata;

  hash_mem_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .a_addr  (mem_addr[IW-1:0]),
    .a_rdata (ram_a_rdata),
    .b_addr  (host_addr[IW-1:0]),
    .b_rdata (ram_b_rdata)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    run_end = 1'b0;
    case (state_q)
      IDLE, COMPLETE: if (go) state_d = LAUNCH;
      LAUNCH: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY: begin
        if (!hash_done) begin
          state_d = RUN;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          // Engine never went busy: treat it as finished and close the run.
          state_d = COMPLETE;
          run_end = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RUN: begin
        if (hash_done && !done_q) begin
          state_d = COMPLETE;
          run_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      done_q        <= 1'b0;
      irq_q         <= 1'b0;
      host_rvalid_q <= 1'b0;
      eng_oor_q     <= 1'b0;
      host_oor_q    <= 1'b0;
      wr_count_q    <= '0;
      err_oor_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      done_q        <= hash_done;
      irq_q         <= run_end;
      host_rvalid_q <= host_gnt & ~host_we;
      eng_oor_q     <= ~eng_in;
      host_oor_q    <= ~host_in;

      if (launch)                             wr_count_q <= '0;
      else if (eng_wr_ok && wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;

      // A fresh out-of-range hit wins over the clear at launch.
      if (oor_evt)     err_oor_q <= 1'b1;
      else if (launch) err_oor_q <= 1'b0;
    end
  end

  assign mem_read_data = eng_oor_q  ? OOR_DATA : ram_a_rdata;
  assign host_rdata    = host_oor_q ? OOR_DATA : ram_b_rdata;
  assign host_rvalid   = host_rvalid_q;
  assign hash_start    = (state_q == LAUNCH);
  assign irq           = irq_q;
  assign wr_count      = wr_count_q;
  assign err_oor       = err_oor_q;

endmodule

// File: tb/tb_hash_mem_responder.sv
module tb_hash_mem_responder;
  localparam int DEPTH = 1024;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data, mem_read_data;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic          go, hash_start, hash_done, irq, err_oor;
  logic [7:0]    wr_count;

  always #5 clk = ~clk;

  hash_mem_responder #(.DEPTH(DEPTH), .AW(AW), .OOR_DATA(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_clk(clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .go(go), .hash_start(hash_start), .hash_done(hash_done), .irq(irq),
    .wr_count(wr_count), .err_oor(err_oor)
  );

  // Reference: what the RAM should hold, from the rules of the block.
  logic [31:0] ref_mem [DEPTH];
  int          pre_addrs[$];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    host_req = 1; host_we = 1; host_addr = AW'(a); host_wdata = d;
    #1 chk("host_gnt_wr", {31'b0, host_gnt}, 1);
    tick();
    host_req = 0; host_we = 0;
    if (a < DEPTH) ref_mem[a] = d;
  endtask

  task automatic host_read(input int a);
    logic [31:0] exp;
    exp = (a < DEPTH) ? ref_mem[a] : 32'h0;
    host_req = 1; host_we = 0; host_addr = AW'(a);
    #1 chk("host_gnt_rd", {31'b0, host_gnt}, 1);
    tick();
    chk("host_rvalid", {31'b0, host_rvalid}, 1);
    chk($sformatf("host_rdata[%0h]", a), host_rdata, exp);
    host_req = 0;
  endtask

  // One engine run: nw writes at base+(i%span); write index oor_at goes out of range.
  task automatic run_engine(input int nw, input int base, input int span, input int oor_at);
    int exp_cnt = 0, irqs = 0, last = -1;
    bit exp_err = 0;
    int a;
    logic [31:0] d;
    go = 1;
    #1 chk("start_pre", {31'b0, hash_start}, 0);
    tick();
    go = 0;
    chk("start_pulse", {31'b0, hash_start}, 1);
    chk("err_clr", {31'b0, err_oor}, 0);
    chk("wrc_clr", {24'b0, wr_count}, 0);
    hash_done = 0;
    tick();
    chk("start_fall", {31'b0, hash_start}, 0);
    tick();
    for (int i = 0; i < nw; i++) begin
      a = (i == oor_at) ? 32'h400 : base + (i % span);
      d = $urandom;
      mem_we = 1; mem_addr = AW'(a); mem_write_data = d;
      go = (i % 3 == 0); host_req = 1; host_we = 0; host_addr = 16'd5;
      #1;
      if (i < 4) chk("gnt_in_run", {31'b0, host_gnt}, 0);
      tick();
      irqs += int'(irq);
      if (i < 4) chk("no_restart", {31'b0, hash_start}, 0);
      if (a < DEPTH) begin
        ref_mem[a] = d; exp_cnt++; last = a;
        if (i < 8) chk("write_first", mem_read_data, d);
      end else begin
        exp_err = 1;
        chk("oor_rdata", mem_read_data, 32'h0);
      end
    end
    mem_we = 0; go = 0; host_req = 0; hash_done = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      irqs += int'(irq);
    end
    chk("irq_once", irqs, 1);
    chk("wr_count", {24'b0, wr_count}, (exp_cnt > 255) ? 255 : exp_cnt);
    chk("err_oor", {31'b0, err_oor}, {31'b0, exp_err});
    if (last >= 0) host_read(last);
  endtask

  initial begin
    int cyc;
    int a;
    reset = 1; mem_we = 0; mem_addr = '0; mem_write_data = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    go = 0; hash_done = 1;
    repeat (3) tick();
    chk("rst_start", {31'b0, hash_start}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_wrc", {24'b0, wr_count}, 0);
    chk("rst_err", {31'b0, err_oor}, 0);
    chk("rst_rvalid", {31'b0, host_rvalid}, 0);
    chk("rst_mrd", mem_read_data, 0);
    chk("rst_hrd", host_rdata, 0);
    reset = 0;
    tick();

    // Preload: fixed pattern plus random words.
    for (int n = 0; n <= 20; n++) host_write(n, 32'h1111_0000 + n);
    for (int n = 0; n < 20; n++) begin
      a = $urandom_range(32'h2FF, 32'h200);
      host_write(a, $urandom);
      pre_addrs.push_back(a);
    end
    host_read(5);
    tick();
    chk("rvalid_drop", {31'b0, host_rvalid}, 0);
    foreach (pre_addrs[i]) if (i < 5) host_read(pre_addrs[i]);

    // Engine read latency.
    mem_addr = 16'd3;
    tick();
    chk("eng_rd_lat", mem_read_data, 32'h1111_0003);
    mem_addr = 16'd20;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("eng_rd_hold", mem_read_data, 32'h1111_0014);
    end

    // Host out-of-range read raises the sticky flag.
    host_read(32'h500);
    chk("host_oor_err", {31'b0, err_oor}, 1);

    run_engine(16, 32'h100, 16, -1);
    run_engine($urandom_range(30, 5), $urandom_range(32'h3E0, 32'h300), 16, 2);
    run_engine(260, 32'h100, 256, -1);

    // Engine writes outside a run are dropped.
    mem_we = 1; mem_addr = 16'd2; mem_write_data = 32'hDEAD_BEEF;
    tick();
    mem_we = 0;
    chk("drop_idle_wr", mem_read_data, ref_mem[2]);
    host_read(2);

    // Start timeout: engine never drops done.
    go = 1;
    tick();
    go = 0; host_req = 1; host_we = 0; host_addr = '0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!host_gnt && cyc < 40);
    host_req = 0;
    chk("tmo_len", cyc, 17);
    chk("tmo_wrc", {24'b0, wr_count}, 0);

    // Reset during a run.
    go = 1; tick(); go = 0; hash_done = 0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      mem_we = 1; mem_addr = AW'(32'h150 + k); mem_write_data = $urandom;
      ref_mem[32'h150 + k] = mem_write_data;
      tick();
    end
    mem_we = 0; reset = 1;
    tick();
    reset = 0; hash_done = 1;
    chk("mrst_start", {31'b0, hash_start}, 0);
    chk("mrst_irq", {31'b0, irq}, 0);
    chk("mrst_wrc", {24'b0, wr_count}, 0);
    host_req = 1; host_we = 0;
    #1 chk("mrst_idle_gnt", {31'b0, host_gnt}, 1);
    host_req = 0;
    for (int n = 0; n <= 20; n += 4) host_read(n);
    host_read(32'h151);
    foreach (pre_addrs[i]) if (i >= 15) host_read(pre_addrs[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
